// File: rtl/link_freq_meter.sv
// =============================================================================
// Module   : link_freq_meter
// Brief    : Link input conditioner, period meter and lock detector for the PLL.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module link_freq_meter #(
    parameter int CLK_HZ        = 100000000,
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4,
    parameter int MIN_PERIOD    = 1786,
    parameter int MAX_PERIOD    = 3846,
    parameter int TOL           = 16,
    parameter int LOCK_COUNT    = 8,
    parameter int TIMEOUT       = 8000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        link,
    output logic        link_clean,
    output logic [31:0] period_out,
    output logic [31:0] f_meas,
    output logic        freq_rdy,
    output logic        link_lost
);

    localparam int c_DG_W    = $clog2(GLITCH_CYCLES + 1);
    localparam int c_MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [31:0] c_CLK     = 32'(CLK_HZ);
    localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT);
    localparam logic [31:0] c_MIN     = 32'(MIN_PERIOD);
    localparam logic [31:0] c_MAX     = 32'(MAX_PERIOD);
    localparam logic signed [32:0] c_TOL = 33'(TOL);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MEASURE = 2'd1;
    localparam logic [1:0] c_TRACK   = 2'd2;
    localparam logic [1:0] c_LOCKED  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DG_W-1:0]      r_dg_cnt;
    logic                   r_clean;
    logic                   r_clean_d;
    logic [31:0]            r_cnt;
    logic [31:0]            r_ref;
    logic [c_MATCH_W-1:0]   r_match;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [31:0]            r_period;
    logic [31:0]            r_fmeas;
    logic                   r_freq_rdy;
    logic                   r_link_lost;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_inrange;
    logic                   w_near;
    logic                   w_timeout;
    logic signed [32:0]     w_diff;
    logic [c_MATCH_W-1:0]   w_match_inc;
    logic                   w_lock_hit;
    logic                   w_ref_ld;
    logic                   w_match_ld;
    logic [c_MATCH_W-1:0]   w_match_nxt;
    logic                   w_pout_ld;

    logic [5:0]             r_div_cnt;
    logic [31:0]            r_divisor;
    logic [31:0]            r_quot;
    logic [31:0]            r_rem;
    logic [32:0]            w_rem_sh;
    logic                   w_ge;
    logic [31:0]            w_rem_nxt;
    logic [31:0]            w_quot_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = r_clean & ~r_clean_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync    <= '0;
            r_dg_cnt  <= '0;
            r_clean   <= 1'b0;
            r_clean_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], link};
            r_clean_d <= r_clean;
            if (w_sync != r_clean) begin
                if (r_dg_cnt == c_DG_W'(GLITCH_CYCLES - 1)) begin
                    r_clean  <= w_sync;
                    r_dg_cnt <= '0;
                end else begin
                    r_dg_cnt <= r_dg_cnt + 1'b1;
                end
            end else begin
                r_dg_cnt <= '0;
            end
        end
    end

    // cnt sampled on a rise cycle is the exact period since the previous rise
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= 32'd1;
        end else if (r_cnt != c_TIMEOUT) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign w_inrange   = (r_cnt >= c_MIN) && (r_cnt <= c_MAX);
    assign w_diff      = $signed({1'b0, r_cnt}) - $signed({1'b0, r_ref});
    assign w_near      = (w_diff <= c_TOL) && (w_diff >= -c_TOL);
    assign w_match_inc = r_match + 1'b1;
    assign w_lock_hit  = (w_match_inc == c_MATCH_W'(LOCK_COUNT));
    assign w_timeout   = (r_state != c_IDLE) && (r_cnt == c_TIMEOUT) && !w_rise;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_rise) begin
            case (r_state)
                c_IDLE:    w_state_nxt = c_MEASURE;
                c_MEASURE: if (w_inrange) w_state_nxt = c_TRACK;
                c_TRACK: begin
                    if (!w_inrange)
                        w_state_nxt = c_MEASURE;
                    else if (w_near && w_lock_hit)
                        w_state_nxt = c_LOCKED;
                end
                c_LOCKED: begin
                    if (!w_inrange)
                        w_state_nxt = c_MEASURE;
                    else if (!w_near)
                        w_state_nxt = c_TRACK;
                end
                default:   w_state_nxt = c_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_comb begin
        w_ref_ld    = 1'b0;
        w_match_ld  = 1'b0;
        w_match_nxt = r_match;
        w_pout_ld   = 1'b0;
        if (w_rise) begin
            case (r_state)
                c_MEASURE: begin
                    if (w_inrange) begin
                        w_ref_ld    = 1'b1;
                        w_match_ld  = 1'b1;
                        w_match_nxt = c_MATCH_W'(1);
                    end
                end
                c_TRACK: begin
                    w_ref_ld   = 1'b1;
                    w_match_ld = 1'b1;
                    if (w_inrange && w_near) begin
                        w_match_nxt = w_match_inc;
                        w_pout_ld   = w_lock_hit;
                    end else begin
                        w_match_nxt = w_inrange ? c_MATCH_W'(1) : '0;
                    end
                end
                c_LOCKED: begin
                    w_ref_ld = 1'b1;
                    if (w_inrange && w_near) begin
                        w_pout_ld = 1'b1;
                    end else begin
                        w_match_ld  = 1'b1;
                        w_match_nxt = w_inrange ? c_MATCH_W'(1) : '0;
                    end
                end
                default: ;
            endcase
        end else if (w_timeout) begin
            w_match_ld  = 1'b1;
            w_match_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ref       <= '0;
            r_match     <= '0;
            r_period    <= '0;
            r_freq_rdy  <= 1'b0;
            r_link_lost <= 1'b0;
        end else begin
            if (w_ref_ld)   r_ref    <= r_cnt;
            if (w_match_ld) r_match  <= w_match_nxt;
            if (w_pout_ld)  r_period <= r_cnt;
            r_freq_rdy  <= (w_state_nxt == c_LOCKED);
            r_link_lost <= w_timeout;
        end
    end

    // Restoring divider, 32 steps; f_meas keeps its old value until done
    assign w_rem_sh   = {r_rem, r_quot[31]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nxt  = w_ge ? 32'(w_rem_sh - {1'b0, r_divisor}) : w_rem_sh[31:0];
    assign w_quot_nxt = {r_quot[30:0], w_ge};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_div_cnt <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_fmeas   <= '0;
        end else if (w_pout_ld) begin
            r_div_cnt <= 6'd32;
            r_divisor <= r_cnt;
            r_quot    <= c_CLK;
            r_rem     <= '0;
        end else if (r_div_cnt != 6'd0) begin
            r_div_cnt <= r_div_cnt - 6'd1;
            r_quot    <= w_quot_nxt;
            r_rem     <= w_rem_nxt;
            if (r_div_cnt == 6'd1) r_fmeas <= w_quot_nxt;
        end
    end

    assign link_clean = r_clean;
    assign period_out = r_period;
    assign f_meas     = r_fmeas;
    assign freq_rdy   = r_freq_rdy;
    assign link_lost  = r_link_lost;

endmodule

`default_nettype wire

// File: tb/tb_link_freq_meter.sv
// =============================================================================
// Module   : tb_link_freq_meter
// Brief    : Directed, table-driven bench for link_freq_meter.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_link_freq_meter;

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    logic        link = 1'b0;
    logic        link_clean;
    logic [31:0] period_out;
    logic [31:0] f_meas;
    logic        freq_rdy;
    logic        link_lost;

    link_freq_meter dut (
        .clk        (clk),
        .nrst       (nrst),
        .link       (link),
        .link_clean (link_clean),
        .period_out (period_out),
        .f_meas     (f_meas),
        .freq_rdy   (freq_rdy),
        .link_lost  (link_lost)
    );

    always #5 clk = ~clk;

    int ncomp    = 0;
    int nfail    = 0;
    int cyc      = 0;
    int lost_cnt = 0;
    int lost_at  = -1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (link_lost) begin
            lost_cnt = lost_cnt + 1;
            lost_at  = cyc;
        end
    end

    typedef struct {
        int   per;
        int   high;
        int   n;
        logic rdy;
        int   pout;
        int   fm;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input longint act, input longint exp);
        ncomp = ncomp + 1;
        if (act !== exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_wave(input int per, input int high, input int n);
        for (int i = 0; i < n; i++) begin
            link = 1'b1;
            repeat (high) @(negedge clk);
            link = 1'b0;
            repeat (per - high) @(negedge clk);
        end
    endtask

    task automatic apply_vec(input int i);
        run_wave(vt[i].per, vt[i].high, vt[i].n);
        chk($sformatf("v%0d freq_rdy", i), longint'(freq_rdy), longint'(vt[i].rdy));
        chk($sformatf("v%0d period_out", i), longint'(period_out), longint'(vt[i].pout));
        chk($sformatf("v%0d f_meas", i), longint'(f_meas), longint'(vt[i].fm));
    endtask

    initial begin
        int seen_clean;
        int rdy_drop;
        int lost0;
        int w0;

        // 1e8/2440 = 40983.6 -> 40983 ; 1e8/2600 = 38461.5 -> 38461
        vt[0] = '{per: 5000, high: 2500, n: 2, rdy: 1'b0, pout: 0,    fm: 0};
        vt[1] = '{per: 2440, high: 1220, n: 8, rdy: 1'b0, pout: 0,    fm: 0};
        vt[2] = '{per: 2440, high: 1220, n: 1, rdy: 1'b1, pout: 2440, fm: 40983};
        vt[3] = '{per: 2440, high: 1220, n: 8, rdy: 1'b0, pout: 0,    fm: 0};
        vt[4] = '{per: 2440, high: 1220, n: 1, rdy: 1'b1, pout: 2440, fm: 40983};
        vt[5] = '{per: 2600, high: 1300, n: 1, rdy: 1'b1, pout: 2440, fm: 40983};
        vt[6] = '{per: 2600, high: 1300, n: 1, rdy: 1'b0, pout: 2440, fm: 40983};
        vt[7] = '{per: 2600, high: 1300, n: 6, rdy: 1'b0, pout: 2440, fm: 40983};
        vt[8] = '{per: 2600, high: 1300, n: 1, rdy: 1'b1, pout: 2600, fm: 38461};

        repeat (5) @(negedge clk);
        chk("rst link_clean", longint'(link_clean), 0);
        chk("rst freq_rdy", longint'(freq_rdy), 0);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle period_out", longint'(period_out), 0);
        chk("idle f_meas", longint'(f_meas), 0);
        chk("idle link_lost", longint'(lost_cnt), 0);

        // 20 kHz never locks, then 41 kHz locks on the 9th rise
        for (int i = 0; i <= 2; i++) apply_vec(i);

        // 3-cycle glitches in the low phase while locked
        seen_clean = 0;
        rdy_drop   = 0;
        link = 1'b1;
        repeat (1220) @(negedge clk);
        for (int j = 0; j < 1220; j++) begin
            link = ((j >= 300 && j < 303) || (j >= 603 && j < 606)) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (j >= 20 && link_clean) seen_clean = 1;
            if (!freq_rdy) rdy_drop = 1;
        end
        chk("glitch link_clean", longint'(seen_clean), 0);
        chk("glitch freq_rdy held", longint'(rdy_drop), 0);
        chk("glitch period_out", longint'(period_out), 2440);

        // asynchronous reset in the middle of a locked high phase
        link = 1'b1;
        repeat (100) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("arst link_clean", longint'(link_clean), 0);
        chk("arst freq_rdy", longint'(freq_rdy), 0);
        chk("arst period_out", longint'(period_out), 0);
        chk("arst f_meas", longint'(f_meas), 0);
        chk("arst link_lost", longint'(link_lost), 0);
        @(negedge clk);
        link = 1'b0;
        repeat (5) @(negedge clk);
        nrst = 1'b1;

        // relock, then step the period 2440 -> 2600
        for (int i = 3; i <= 8; i++) apply_vec(i);
        chk("pre-timeout link_lost", longint'(lost_cnt), 0);

        // hold link low: exactly one loss pulse ~8000 cycles after last rise
        lost0 = lost_cnt;
        w0    = cyc;
        repeat (6000) @(negedge clk);
        chk("timeout pulses", longint'(lost_cnt - lost0), 1);
        chk("timeout timing", longint'((lost_at - w0 >= 5395) && (lost_at - w0 <= 5420)), 1);
        chk("timeout freq_rdy", longint'(freq_rdy), 0);
        chk("timeout period_out", longint'(period_out), 2600);
        chk("timeout f_meas", longint'(f_meas), 38461);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
